// File: rtl/cache_pkg.sv
// Shared defaults, FSM encoding and byte-enable merge helper for the cache tag/data store.
package cache_pkg;

    localparam int unsigned CACHE_DATA_W  = 32;
    localparam int unsigned CACHE_TAG_W   = 20;
    localparam int unsigned CACHE_INDEX_W = 10;

    // Widest word the merge helper handles; callers cast in and out of this width.
    localparam int unsigned MERGE_MAX_W   = 1024;
    localparam int unsigned MERGE_MAX_BE  = MERGE_MAX_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } cache_state_e;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [MERGE_MAX_W-1:0] be_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < MERGE_MAX_BE; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/cache_sram_1p.sv
// Single-port RAM with byte-enable writes and a registered, write-first read port.
// The read register holds its value until the next read and is the only resettable state.
module cache_sram_1p
    import cache_pkg::*;
#(
    parameter int unsigned  WIDTH  = 32,
    parameter int unsigned  ADDR_W = 10,
    localparam int unsigned BE_W   = (WIDTH + 7) / 8,
    localparam int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  din,
    input  logic [BE_W-1:0]   be,
    output logic [WIDTH-1:0]  dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] merged;

    // Stored word at addr with the enabled bytes of din overlaid.
    always_comb begin
        merged = WIDTH'(be_merge(MERGE_MAX_W'(mem[addr]), MERGE_MAX_W'(din), MERGE_MAX_BE'(be)));
    end

    // Array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= merged;
        end
    end

    // Registered read; a simultaneous write is returned as the merged new word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (re) begin
            dout <= we ? merged : mem[addr];
        end
    end

endmodule

// File: rtl/cache_tag_data_store.sv
// Tag + data + valid store for the I/D caches: 1-cycle registered lookup with hit,
// byte-enable fills, single-line invalidate and a sequential valid-clear sweep that
// runs after reset and on flush. hit is decoded purely from registered state
// (rd_valid, rd_tag, captured cmp_tag), so it only changes at clock edges.
module cache_tag_data_store
    import cache_pkg::*;
#(
    parameter int unsigned  DATA_W  = CACHE_DATA_W,
    parameter int unsigned  TAG_W   = CACHE_TAG_W,
    parameter int unsigned  INDEX_W = CACHE_INDEX_W,
    localparam int unsigned BE_W    = DATA_W / 8,
    localparam int unsigned DEPTH   = 1 << INDEX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index,
    input  logic               rd_en,
    input  logic [TAG_W-1:0]   cmp_tag,
    input  logic               wr_en,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [BE_W-1:0]    wr_be,
    input  logic               inv_en,
    input  logic               flush,
    output logic               ready,
    output logic [DATA_W-1:0]  rd_data,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    output logic               hit,
    output logic               flush_done
);

    localparam int unsigned TAG_BE_W = (TAG_W + 7) / 8;

    cache_state_e       state;
    logic [INDEX_W-1:0] clr_cnt;
    logic [DEPTH-1:0]   valid;
    logic [TAG_W-1:0]   cmp_tag_q;
    logic               accept;
    logic               rd_go;
    logic               wr_go;

    // Requests are honoured only in IDLE and never while reset is asserted.
    always_comb begin
        accept = rst_n && (state == ST_IDLE);
        rd_go  = accept && rd_en;
        wr_go  = accept && wr_en;
    end

    // Control FSM: sweep valid bits in CLEAR, accept requests in IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_CLEAR;
            clr_cnt    <= '0;
            ready      <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + INDEX_W'(1);
                    if (clr_cnt == INDEX_W'(DEPTH - 1)) begin
                        state      <= ST_IDLE;
                        ready      <= 1'b1;
                        flush_done <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (flush) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        ready   <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

    // Valid bits: cleared one line per cycle by the sweep; write beats invalidate.
    always_ff @(posedge clk) begin
        if (rst_n && (state == ST_CLEAR)) begin
            valid[clr_cnt] <= 1'b0;
        end else if (wr_go) begin
            valid[index] <= 1'b1;
        end else if (accept && inv_en) begin
            valid[index] <= 1'b0;
        end
    end

    // Lookup valid and compare tag, captured with the request; forced invalid in CLEAR.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            cmp_tag_q <= '0;
        end else if (state == ST_CLEAR) begin
            rd_valid  <= 1'b0;
        end else if (rd_en) begin
            cmp_tag_q <= cmp_tag;
            rd_valid  <= wr_en || (valid[index] && !inv_en);
        end
    end

    // Hit from registered lookup state only.
    always_comb begin
        hit = rd_valid && (rd_tag == cmp_tag_q);
    end

    cache_sram_1p #(
        .WIDTH  (DATA_W),
        .ADDR_W (INDEX_W)
    ) u_data_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (rd_go),
        .we    (wr_go),
        .addr  (index),
        .din   (wr_data),
        .be    (wr_be),
        .dout  (rd_data)
    );

    cache_sram_1p #(
        .WIDTH  (TAG_W),
        .ADDR_W (INDEX_W)
    ) u_tag_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .re    (rd_go),
        .we    (wr_go),
        .addr  (index),
        .din   (wr_tag),
        .be    ({TAG_BE_W{1'b1}}),
        .dout  (rd_tag)
    );

endmodule
